// File: rtl/rv_pipe_pkg.sv
// Shared types and constants for the EX->MEM pipeline register.
package rv_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    SKID  = 2'd2
  } skid_state_e;

  localparam int unsigned CTRL_REG_WRITE  = 0;
  localparam int unsigned RD_WIDTH        = 5;
  localparam int unsigned DATA_LENGTH_DEF = 32;
  localparam int unsigned PC_WIDTH_DEF    = 32;
  localparam int unsigned CTRL_WIDTH_DEF  = 6;

  typedef struct packed {
    logic [DATA_LENGTH_DEF-1:0] alu_res;
    logic [DATA_LENGTH_DEF-1:0] w_data;
    logic [RD_WIDTH-1:0]        rd;
    logic [PC_WIDTH_DEF-1:0]    pc_plus4;
    logic [CTRL_WIDTH_DEF-1:0]  ctrl;
  } ex_mem_payload_t;

endpackage

// File: rtl/pipe_slot.sv
// Payload register with load enable; synchronous clear takes priority over load.
module pipe_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (i_clear) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ex_mem_pipe_skid.sv
// EX->MEM pipeline register: registered ready, two-entry skid, sync flush, stall counter.
module ex_mem_pipe_skid
  import rv_pipe_pkg::*;
#(
  parameter int unsigned DATA_LENGTH = 32,
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned CTRL_WIDTH  = 6,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_LENGTH-1:0] alu_res_in,
  input  logic [DATA_LENGTH-1:0] w_data_in,
  input  logic [RD_WIDTH-1:0]    rd_in,
  input  logic [PC_WIDTH-1:0]    pc_plus4_in,
  input  logic [CTRL_WIDTH-1:0]  ctrl_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_LENGTH-1:0] alu_res_out,
  output logic [DATA_LENGTH-1:0] w_data_out,
  output logic [RD_WIDTH-1:0]    rd_out,
  output logic [PC_WIDTH-1:0]    pc_plus4_out,
  output logic [CTRL_WIDTH-1:0]  ctrl_out,
  output logic [CNT_WIDTH-1:0]   stall_cnt
);

  localparam int unsigned PAY_W = 2 * DATA_LENGTH + RD_WIDTH + PC_WIDTH + CTRL_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  skid_state_e           r_state;
  skid_state_e           w_next_state;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [CNT_WIDTH-1:0]  r_stall_cnt;
  logic                  w_in_xfer;
  logic                  w_out_xfer;
  logic                  w_load_out;
  logic                  w_load_skid;
  logic                  w_sel_skid;
  logic [CTRL_WIDTH-1:0] w_ctrl_in;
  logic [PAY_W-1:0]      w_in_pay;
  logic [PAY_W-1:0]      w_skid_q;
  logic [PAY_W-1:0]      w_out_d;
  logic [PAY_W-1:0]      w_out_q;

  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  // Writes to x0 never retire, so reg_write is dropped at capture.
  always_comb begin
    w_ctrl_in = ctrl_in;
    if (rd_in == '0) begin
      w_ctrl_in[CTRL_REG_WRITE] = 1'b0;
    end
  end

  assign w_in_pay = {alu_res_in, w_data_in, rd_in, pc_plus4_in, w_ctrl_in};
  assign w_out_d  = w_sel_skid ? w_skid_q : w_in_pay;

  always_comb begin
    w_next_state = r_state;
    w_load_out   = 1'b0;
    w_load_skid  = 1'b0;
    w_sel_skid   = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_in_xfer) begin
          w_next_state = MAIN;
          w_load_out   = 1'b1;
        end
      end
      MAIN: begin
        if (w_in_xfer && w_out_xfer) begin
          w_load_out = 1'b1;
        end else if (w_in_xfer) begin
          w_next_state = SKID;
          w_load_skid  = 1'b1;
        end else if (w_out_xfer) begin
          w_next_state = EMPTY;
        end
      end
      SKID: begin
        if (w_out_xfer) begin
          w_next_state = MAIN;
          w_load_out   = 1'b1;
          w_sel_skid   = 1'b1;
        end
      end
      default: w_next_state = EMPTY;
    endcase
    if (flush) begin
      w_next_state = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_state     <= w_next_state;
      r_out_valid <= (w_next_state != EMPTY);
      r_in_ready  <= (w_next_state != SKID);
    end
  end

  // Saturating count of cycles MEM holds off a valid entry; survives flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !out_ready && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
    end
  end

  pipe_slot #(.W(PAY_W)) u_skid_slot (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load_skid),
    .i_clear (flush),
    .i_d     (w_in_pay),
    .o_q     (w_skid_q)
  );

  pipe_slot #(.W(PAY_W)) u_out_slot (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load_out),
    .i_clear (flush),
    .i_d     (w_out_d),
    .o_q     (w_out_q)
  );

  assign {alu_res_out, w_data_out, rd_out, pc_plus4_out, ctrl_out} = w_out_q;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign stall_cnt = r_stall_cnt;

endmodule
